// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART receiver.
// A byte is captured on each rising edge of in_ready. It is then held in a
// first-word-fall-through FIFO until a consumer pops it.
//
// Handshake: out_valid means out_data holds the oldest stored byte.
// A pop happens on a clock edge only when out_rd and out_valid are both high.
// The consumer samples out_data in the same cycle in which it asserts out_rd.
// out_rd while out_valid is low has no effect.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  out_rd,
  input  logic                  flush,
  input  logic                  clr_overrun,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  overrun
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wp;
  logic [DEPTH_LOG2-1:0] r_rp;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_in_ready_q;
  logic                  r_overrun;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_valid;
  logic w_wr_en;
  logic w_drop;

  // A push arriving together with a pop is accepted even when full, because
  // the pop frees a slot in the same edge. Flush overrides both.
  always_comb begin
    w_valid = (r_count != '0);
    w_full  = (r_count == FULL_COUNT);
    w_push  = in_ready & ~r_in_ready_q;
    w_pop   = out_rd & w_valid & ~flush;
    w_wr_en = w_push & ~flush & (w_pop | ~w_full);
    w_drop  = w_push & ~flush & ~w_pop & w_full;
  end

  // Track in_ready every cycle, flush included, so that a level held high
  // through a flush does not produce a second push afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_in_ready_q <= 1'b0;
    else        r_in_ready_q <= in_ready;
  end

  // Storage array. Its contents are not reset; occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wp] <= in_data;
  end

  // Pointers and occupancy. Pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_en) r_wp <= r_wp + 1'b1;
      if (w_pop)   r_rp <= r_rp + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overrun: a dropped byte sets it and wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_overrun <= 1'b0;
    else if (w_drop)      r_overrun <= 1'b1;
    else if (clr_overrun) r_overrun <= 1'b0;
  end

  // Outputs come from registered state; out_data is a fall-through read.
  always_comb begin
    out_valid = w_valid;
    out_data  = r_mem[r_rp];
    count     = r_count;
    full      = w_full;
    overrun   = r_overrun;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_rd;
  logic       flush;
  logic       clr_overrun;
  logic       out_valid;
  logic [7:0] out_data;
  logic [4:0] count;
  logic       full;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_rd      (out_rd),
    .flush       (flush),
    .clr_overrun (clr_overrun),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .count       (count),
    .full        (full),
    .overrun     (overrun)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise in_ready with a byte for 'hold' cycles, then drop it for one cycle
  task automatic push_byte(input logic [7:0] d, input int hold);
    in_ready = 1'b1;
    in_data  = d;
    repeat (hold) step();
    in_ready = 1'b0;
    step();
  endtask

  // Check the head byte, then pop it
  task automatic pop_byte(input logic [7:0] exp, input string name);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s valid: got %b exp 1", name, out_valid);
    end
    checks++;
    if (out_data !== exp) begin
      errors++;
      $display("FAIL %s data: got %h exp %h", name, out_data, exp);
    end
    out_rd = 1'b1;
    step();
    out_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_ready = 1'b0; in_data = '0;
    out_rd = 1'b0; flush = 1'b0; clr_overrun = 1'b0;
    repeat (2) step();
    checks++;
    if ({out_valid, full, overrun, count} !== 8'b000_00000) begin
      errors++;
      $display("FAIL reset: got valid=%b full=%b ovr=%b cnt=%0d exp all 0",
               out_valid, full, overrun, count);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    push_byte(8'h41, 3);
    push_byte(8'h42, 3);
    push_byte(8'h43, 3);
    checks++;
    if (count !== 5'd3) begin
      errors++; $display("FAIL basic count: got %0d exp 3", count);
    end
    pop_byte(8'h41, "basic pop0");
    pop_byte(8'h42, "basic pop1");
    pop_byte(8'h43, "basic pop2");
    checks++;
    if (out_valid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL basic empty: got valid=%b cnt=%0d exp 0/0", out_valid, count);
    end
    // out_rd while empty must be ignored
    out_rd = 1'b1;
    step();
    out_rd = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL empty pop: got valid=%b cnt=%0d exp 0/0", out_valid, count);
    end
  endtask

  task automatic test_level_held();
    push_byte(8'h55, 20);
    checks++;
    if (count !== 5'd1) begin
      errors++; $display("FAIL level held count: got %0d exp 1", count);
    end
    pop_byte(8'h55, "level held pop");
  endtask

  task automatic test_full_overrun();
    for (int i = 0; i < 17; i++) push_byte(8'(i), 1);
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun state: got full=%b cnt=%0d ovr=%b exp 1/16/1",
               full, count, overrun);
    end
    for (int i = 0; i < 16; i++) pop_byte(8'(i), "overrun drain");
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL overrun drained valid: got %b exp 0", out_valid);
    end
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL clr_overrun: got %b exp 0", overrun);
    end
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1);
    checks++;
    if (full !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL simul prefill: got full=%b ovr=%b exp 1/0", full, overrun);
    end
    in_ready = 1'b1;
    in_data  = 8'hAA;
    checks++;
    if (out_data !== 8'h00) begin
      errors++; $display("FAIL simul head: got %h exp 00", out_data);
    end
    out_rd = 1'b1;
    step();
    out_rd   = 1'b0;
    in_ready = 1'b0;
    checks++;
    if (count !== 5'd16 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL simul full: got cnt=%0d ovr=%b exp 16/0", count, overrun);
    end
    for (int i = 1; i < 16; i++) pop_byte(8'(i), "simul drain");
    pop_byte(8'hAA, "simul last");
    checks++;
    if (count !== 5'd0) begin
      errors++; $display("FAIL simul empty count: got %0d exp 0", count);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 40; i++) begin
      in_ready = 1'b1;
      in_data  = 8'(8'h60 + i);
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'(8'h60 + i - 1)) begin
          errors++;
          $display("FAIL wrap data %0d: got v=%b %h exp 1 %h",
                   i, out_valid, out_data, 8'(8'h60 + i - 1));
        end
        out_rd = 1'b1;
      end
      step();
      out_rd   = 1'b0;
      in_ready = 1'b0;
      checks++;
      if (count > 5'd2) begin
        errors++; $display("FAIL wrap count %0d: got %0d exp <=2", i, count);
      end
      step();
    end
    pop_byte(8'h60 + 8'd39, "wrap last");
    checks++;
    if (count !== 5'd0) begin
      errors++; $display("FAIL wrap empty: got %0d exp 0", count);
    end
  endtask

  task automatic test_flush_reset();
    // Make overrun sticky, then flush and confirm it survives
    for (int i = 0; i < 17; i++) push_byte(8'(i), 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (count !== 5'd0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL flush full: got cnt=%0d ovr=%b exp 0/1", count, overrun);
    end
    for (int i = 0; i < 5; i++) push_byte(8'(8'h30 + i), 1);
    checks++;
    if (count !== 5'd5) begin
      errors++; $display("FAIL refill 5: got %0d exp 5", count);
    end
    flush    = 1'b1;
    in_ready = 1'b1;
    in_data  = 8'h77;
    step();
    flush    = 1'b0;
    in_ready = 1'b0;
    checks++;
    if (count !== 5'd0 || out_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL flush+push: got cnt=%0d v=%b ovr=%b exp 0/0/1",
               count, out_valid, overrun);
    end
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(8'(8'h50 + i), 1);
    checks++;
    if (count !== 5'd3 || out_data !== 8'h50) begin
      errors++;
      $display("FAIL refill 3: got cnt=%0d d=%h exp 3/50", count, out_data);
    end
    // Asynchronous reset between edges, with in_ready already high
    #2;
    in_ready = 1'b1;
    in_data  = 8'h99;
    rst_n    = 1'b0;
    #1;
    checks++;
    if (count !== 5'd0 || out_valid !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL async reset: got cnt=%0d v=%b full=%b exp 0/0/0",
               count, out_valid, full);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (count !== 5'd1) begin
      errors++; $display("FAIL push after reset: got cnt=%0d exp 1", count);
    end
    in_ready = 1'b0;
    pop_byte(8'h99, "post reset pop");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_level_held();
    test_full_overrun();
    test_simul_full();
    test_wrap();
    test_flush_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
